divider: RTL and testbench
==========================

// Module: divider
// PURPOSE
// - Iterative 32-bit integer divider for the MIPS core's HI/LO unit (DIV/DIVU).
// - Instantiated twice by the multiply/divide bridge:
//   - SIGNED=1 serves as Divider.
//   - SIGNED=0 serves as Divider_Unsighed.
// - AXI-stream-style interface: one operand pair in; one 64-bit {quotient, remainder} result out a fixed 34 cycles later.
// PARAMETERS
// - SIGNED   1   1: two's-complement divide (DIV); 0: unsigned divide (DIVU)
// PORTS
// - aclk                     in   1   clock; all state changes on its rising edge
// - areset                   in   1   reset, synchronous, active-high
// - s_axis_divisor_tvalid    in   1   divisor valid (start qualifier)
// - s_axis_divisor_tdata     in   32  divisor
// - s_axis_dividend_tvalid   in   1   dividend valid (start qualifier)
// - s_axis_dividend_tdata    in   32  dividend
// - m_axis_dout_tvalid       out  1   result valid, one-cycle pulse
// - m_axis_dout_tdata        out  64  [63:32] quotient, [31:0] remainder
// BEHAVIOUR
// - Reset: areset high at a rising edge clears busy, iteration counter and datapath.
//   - m_axis_dout_tvalid=0 and m_axis_dout_tdata=64'h0 from the next cycle.
//   - Reset mid-operation aborts the division; no result pulse follows.
// - Start: operands are accepted at edge T when all of the following hold:
//   - s_axis_divisor_tvalid=1 and s_axis_dividend_tvalid=1 (single-cycle pulse from the bridge);
//   - the unit is idle;
//   - areset=0.
//   - Both tdata buses are captured at edge T.
//   - If only one tvalid is high, nothing starts.
// - Busy: no tready. A start attempt while busy is ignored; the captured operands are not disturbed.
// - Latency: m_axis_dout_tvalid is high for exactly one cycle, the cycle following edge T+34.
//   - The unit is idle in that same cycle, so a new start may be accepted at edge T+35.
// - m_axis_dout_tdata is updated at the edge that raises tvalid.
//   - It holds that value until the next completion or reset.
//   - No backpressure: the result is never stalled.
// - Algorithm (SIGNED=1):
//   - Take magnitudes of both operands.
//   - Run 32 restoring or non-restoring shift/subtract steps (1 bit per cycle); the remaining cycles are operand prep and sign fix-up.
//   - Quotient is truncated toward zero.
//   - Quotient is negated when the operand signs differ.
//   - Remainder takes the sign of the dividend.
//   - Identity: dividend = Q*divisor + R, with |R| < |divisor|.
// - SIGNED=0: plain unsigned 32/32 divide, same timing.
// - Boundary cases:
//   - Divide by zero (either mode): Q=32'hFFFFFFFF, R=dividend; timing unchanged.
//   - Signed overflow 32'h80000000 / 32'hFFFFFFFF: Q=32'h80000000, R=0.
//   - Dividend < divisor (unsigned): Q=0, R=dividend.
//   - Dividend 0: Q=0, R=0.
// - Latency is fixed at 34 for all operand values; there is no early termination.
// TESTING
// - Unsigned 100/7 started at edge T:
//   - tvalid pulses only in the cycle after edge T+34;
//   - tdata=64'h0000000E_00000002.
// - Signed -7/2 (32'hFFFFFFF9 / 32'h2):
//   - tdata={32'hFFFFFFFD, 32'hFFFFFFFF}.
//   - Also signed 7/-2: {32'hFFFFFFFD, 32'h00000001}.
// - Signed 32'h80000000 / 32'hFFFFFFFF -> {32'h80000000, 32'h0}.
//   - Same operands with SIGNED=0 -> {32'h00000000, 32'h80000000}.
// - Divide by zero, dividend 32'h12345678 (both modes):
//   - tdata={32'hFFFFFFFF, 32'h12345678}, after 34 cycles.
// - Start issued at T+5 while busy is ignored:
//   - the first result is unchanged at T+34, with a single pulse;
//   - a start at T+35 yields its own result at T+69.
// - areset high at T+10 mid-divide:
//   - no tvalid pulse ever appears for that operation;
//   - tdata reads 0;
//   - the next start completes normally after 34 cycles.

Source files
------------

// File: rtl/divider_if.sv
// Operand/result stream bundle between the multiply/divide bridge and a divider.
// The bridge drives the operand channels (master); the divider answers on dout (slave).
interface divider_if;
  logic        s_axis_divisor_tvalid;
  logic [31:0] s_axis_divisor_tdata;
  logic        s_axis_dividend_tvalid;
  logic [31:0] s_axis_dividend_tdata;
  logic        m_axis_dout_tvalid;
  logic [63:0] m_axis_dout_tdata;

  modport master (
    output s_axis_divisor_tvalid, s_axis_divisor_tdata,
    output s_axis_dividend_tvalid, s_axis_dividend_tdata,
    input  m_axis_dout_tvalid, m_axis_dout_tdata
  );

  modport slave (
    input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
    output m_axis_dout_tvalid, m_axis_dout_tdata
  );
endinterface

// File: rtl/divider.sv
// Iterative 32/32 restoring divider (signed or unsigned), fixed 34-cycle latency,
// result {quotient, remainder} as a one-cycle pulse on the dout stream.
module divider #(
  parameter int SIGNED = 1
) (
  input  logic      aclk,
  input  logic      areset,
  divider_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_OUT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] div_q, div_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic [63:0] res_q, res_d;
  logic [63:0] dout_q, dout_d;
  logic        vld_q, vld_d;

  logic        start;
  logic        load_en, step_en, fix_en, out_en;
  logic [32:0] rem_sh;
  logic [33:0] trial;
  logic        sgn_en;

  function automatic logic [31:0] mag(input logic signed [31:0] v, input logic en);
    logic [31:0] r;
    r = $unsigned(v);
    if (en && v < 0) r = ~r + 32'd1;
    return r;
  endfunction

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  assign sgn_en = (SIGNED != 0);
  assign start  = bus.s_axis_divisor_tvalid && bus.s_axis_dividend_tvalid &&
                  (state_q == S_IDLE);

  // State register
  always_ff @(posedge aclk) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt_q == 5'd31) state_d = S_FIX;
      S_FIX:   state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_en = 1'b0;
    step_en = 1'b0;
    fix_en  = 1'b0;
    out_en  = 1'b0;
    case (state_q)
      S_IDLE:  load_en = start;
      S_CALC:  step_en = 1'b1;
      S_FIX:   fix_en  = 1'b1;
      S_OUT:   out_en  = 1'b1;
      default: ;
    endcase
  end

  // Datapath: one restoring shift/subtract per CALC cycle
  always_comb begin
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    res_d     = res_q;
    dout_d    = dout_q;
    vld_d     = 1'b0;
    rem_sh    = {rem_q[31:0], quo_q[31]};
    trial     = {1'b0, rem_sh} - {2'b00, div_q};

    if (load_en) begin
      div_d     = mag(bus.s_axis_divisor_tdata, sgn_en);
      quo_d     = mag(bus.s_axis_dividend_tdata, sgn_en);
      rem_d     = '0;
      cnt_d     = '0;
      neg_quo_d = sgn_en && (bus.s_axis_divisor_tdata[31] ^ bus.s_axis_dividend_tdata[31]);
      neg_rem_d = sgn_en && bus.s_axis_dividend_tdata[31];
      dz_d      = (bus.s_axis_divisor_tdata == 32'd0);
    end

    if (step_en) begin
      cnt_d = cnt_q + 5'd1;
      if (!trial[33]) begin
        rem_d = trial[32:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_sh;
        quo_d = {quo_q[30:0], 1'b0};
      end
    end

    // Divide by zero forces an all-ones quotient regardless of operand signs
    if (fix_en) begin
      res_d[63:32] = dz_q ? 32'hFFFF_FFFF : cond_neg(quo_q, neg_quo_q);
      res_d[31:0]  = cond_neg(rem_q[31:0], neg_rem_q);
    end

    if (out_en) begin
      dout_d = res_q;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      res_q     <= '0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      res_q     <= res_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
    end
  end

  assign bus.m_axis_dout_tvalid = vld_q;
  assign bus.m_axis_dout_tdata  = dout_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the signed and unsigned divider instances.
module tb_divider;

  logic aclk = 1'b0;
  logic areset;
  int   checks = 0;
  int   errors = 0;

  divider_if s_if ();
  divider_if u_if ();

  divider #(.SIGNED(1)) dut_s (.aclk(aclk), .areset(areset), .bus(s_if.slave));
  divider #(.SIGNED(0)) dut_u (.aclk(aclk), .areset(areset), .bus(u_if.slave));

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sgn, input bit vs, input bit vd,
                       input logic [31:0] dvd, input logic [31:0] dvs);
    if (sgn) begin
      s_if.s_axis_divisor_tvalid  = vs;
      s_if.s_axis_dividend_tvalid = vd;
      s_if.s_axis_divisor_tdata   = dvs;
      s_if.s_axis_dividend_tdata  = dvd;
    end else begin
      u_if.s_axis_divisor_tvalid  = vs;
      u_if.s_axis_dividend_tvalid = vd;
      u_if.s_axis_divisor_tdata   = dvs;
      u_if.s_axis_dividend_tdata  = dvd;
    end
  endtask

  task automatic sample(input bit sgn, output logic v, output logic [63:0] d);
    v = sgn ? s_if.m_axis_dout_tvalid : u_if.m_axis_dout_tvalid;
    d = sgn ? s_if.m_axis_dout_tdata  : u_if.m_axis_dout_tdata;
  endtask

  // Start at edge T (the posedge between the two negedges), then watch 40 cycles.
  task automatic run(input string tag, input bit sgn, input logic [31:0] dvd,
                     input logic [31:0] dvs, input logic [63:0] exp);
    int hits, at;
    logic v;
    logic [63:0] d, got;
    hits = 0; at = 0; got = '0;
    @(negedge aclk); drive(sgn, 1'b1, 1'b1, dvd, dvs);
    @(negedge aclk); drive(sgn, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge aclk);
      sample(sgn, v, d);
      if (v) begin hits++; at = k; got = d; end
    end
    chk({tag, "_pulses"}, 64'(hits), 64'd1);
    chk({tag, "_lat"}, 64'(at), 64'd34);
    chk({tag, "_data"}, got, exp);
    sample(sgn, v, d);
    chk({tag, "_hold"}, d, exp);
  endtask

  initial begin
    int hits, at1, at2;
    logic v;
    logic [63:0] d, d1, d2;

    areset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge aclk);
    @(negedge aclk); areset = 1'b0;
    chk("rst_vld_s", 64'(s_if.m_axis_dout_tvalid), 64'd0);
    chk("rst_dat_s", s_if.m_axis_dout_tdata, 64'h0);
    chk("rst_vld_u", 64'(u_if.m_axis_dout_tvalid), 64'd0);
    chk("rst_dat_u", u_if.m_axis_dout_tdata, 64'h0);

    run("u_100_7",   1'b0, 32'd100,        32'd7,          64'h0000000E_00000002);
    run("s_m7_2",    1'b1, 32'hFFFFFFF9,   32'h2,          64'hFFFFFFFD_FFFFFFFF);
    run("s_7_m2",    1'b1, 32'h7,          32'hFFFFFFFE,   64'hFFFFFFFD_00000001);
    run("s_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000);
    run("u_ovf",     1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000);
    run("s_dz",      1'b1, 32'h12345678,   32'h0,          64'hFFFFFFFF_12345678);
    run("u_dz",      1'b0, 32'h12345678,   32'h0,          64'hFFFFFFFF_12345678);
    run("s_dz_neg",  1'b1, 32'hFFFFFFF9,   32'h0,          64'hFFFFFFFF_FFFFFFF9);
    run("u_small",   1'b0, 32'd5,          32'd9,          64'h00000000_00000005);
    run("s_zero",    1'b1, 32'd0,          32'hFFFFFFF3,   64'h0);
    run("s_m100_m7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'h0000000E_FFFFFFFE);
    run("u_max",     1'b0, 32'hFFFFFFFF,   32'h10,         64'h0FFFFFFF_0000000F);

    // Only one tvalid high: nothing may start
    hits = 0;
    @(negedge aclk); drive(1'b0, 1'b1, 1'b0, 32'd50, 32'd5);
    @(negedge aclk); drive(1'b0, 1'b0, 1'b1, 32'd50, 32'd5);
    @(negedge aclk); drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge aclk); sample(1'b0, v, d); if (v) hits++;
    end
    chk("half_valid_pulses", 64'(hits), 64'd0);

    // Start at T+5 while busy is ignored; start at T+35 completes at T+69
    hits = 0; at1 = 0; at2 = 0; d1 = '0; d2 = '0;
    @(negedge aclk); drive(1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
    @(negedge aclk); drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 1; k <= 75; k++) begin
      @(negedge aclk);
      sample(1'b0, v, d);
      if (v) begin
        hits++;
        if (hits == 1) begin at1 = k; d1 = d; end
        else begin at2 = k; d2 = d; end
      end
      if (k == 4)  drive(1'b0, 1'b1, 1'b1, 32'd1000, 32'd10);
      if (k == 5)  drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      if (k == 34) drive(1'b0, 1'b1, 1'b1, 32'd81, 32'd4);
      if (k == 35) drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    chk("busy_pulses", 64'(hits), 64'd2);
    chk("busy_lat1", 64'(at1), 64'd34);
    chk("busy_data1", d1, 64'h0000000E_00000002);
    chk("busy_lat2", 64'(at2), 64'd69);
    chk("busy_data2", d2, 64'h00000014_00000001);

    // Reset at T+10 aborts the operation
    hits = 0;
    @(negedge aclk); drive(1'b1, 1'b1, 1'b1, 32'd100, 32'd7);
    @(negedge aclk); drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 1; k <= 45; k++) begin
      @(negedge aclk);
      sample(1'b1, v, d);
      if (v) hits++;
      if (k == 9)  areset = 1'b1;
      if (k == 10) areset = 1'b0;
    end
    chk("rst_mid_pulses", 64'(hits), 64'd0);
    chk("rst_mid_data", s_if.m_axis_dout_tdata, 64'h0);
    run("s_after_rst", 1'b1, 32'd100, 32'd7, 64'h0000000E_00000002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
